// File: rtl/spike_time_encoder_pkg.sv
// ----------------------------------------------------------------------------
// spike_time_encoder_pkg
//   Shared constants for the spiking layer and its input encoder: default
//   layer dimensions, the NO_SPIKE code, the time_val period lengths for
//   training and test, and the encoder FSM state type.
// ----------------------------------------------------------------------------
package spike_time_encoder_pkg;

   // Layer dimensions
   localparam int DEF_NUM_SPIKES    = 16;
   localparam int DEF_PIXEL_W       = 8;
   localparam int DEF_TIME_W        = 4;
   localparam int DEF_TVAL_W        = 5;
   localparam int DEF_MIN_INTENSITY = 32;

   // Length of one time_val period, in cycles
   localparam int DEF_TRAIN_PERIOD  = 24;
   localparam int DEF_TEST_PERIOD   = 8;

   // A spike time with its MSB set means "this input never spikes"
   localparam logic [DEF_TIME_W-1:0] NO_SPIKE = '1;

   typedef enum logic {
      FILL = 1'b0,   // collecting pixels into the shadow buffer
      FULL = 1'b1    // shadow holds a complete image, waiting for period end
   } enc_state_t;

endpackage

// File: rtl/spike_time_encode.sv
// ----------------------------------------------------------------------------
// spike_time_encode
//   Purely combinational pixel-to-spike-time mapping. Bright pixels map to
//   early times; pixels below MIN_INTENSITY map to all ones (no spike).
//
// Ports:
//   pix         in   PIXEL_W  pixel intensity
//   spike_time  out  TIME_W   encoded spike time
// ----------------------------------------------------------------------------
module spike_time_encode
   import spike_time_encoder_pkg::*;
#(
   parameter int PIXEL_W       = DEF_PIXEL_W,
   parameter int TIME_W        = DEF_TIME_W,
   parameter int MIN_INTENSITY = DEF_MIN_INTENSITY
) (
   input  logic [PIXEL_W-1:0] pix,
   output logic [TIME_W-1:0]  spike_time
);

   // Keep TIME_W-1 significant bits so the result never reaches the MSB,
   // which is reserved for the no-spike code.
   localparam int SHIFT = PIXEL_W - TIME_W + 1;

   logic [PIXEL_W-1:0] inv;

   // (2^PIXEL_W - 1) - pix is just the bitwise inverse.
   assign inv = ~pix;

   always_comb begin
      if (pix < PIXEL_W'(MIN_INTENSITY)) begin
         spike_time = '1;
      end else begin
         spike_time = TIME_W'(inv >> SHIFT);
      end
   end

endmodule

// File: rtl/spike_time_encoder.sv
// ----------------------------------------------------------------------------
// spike_time_encoder
//   Rank-order encoder in front of the spiking layer. Pixels arrive over a
//   valid/ready handshake, are encoded to spike times into a shadow buffer,
//   and the shadow is swapped into spike_times at the time_val period end so
//   the layer sees a stable image for a whole period.
//
// Configuration macro:
//   ENCODER_BLANK_ON_UNDERRUN_EN  when defined, a period end with no complete
//                                 image blanks spike_times and clears
//                                 frame_valid; otherwise the previous image
//                                 is presented again.
//
// Ports:
//   clk          in   1                      clock, rising edge
//   rst          in   1                      asynchronous active-high reset
//   training     in   1                      selects TRAIN/TEST period length
//   time_val     in   TVAL_W                 global period counter
//   pix_valid    in   1                      pixel offered
//   pix_ready    out  1                      encoder can accept a pixel
//   pix_data     in   PIXEL_W                pixel intensity
//   pix_last     in   1                      last pixel of the image
//   spike_times  out  NUM_SPIKES x TIME_W    layer input, registered
//   frame_valid  out  1                      spike_times holds a real image
//   frame_cnt    out  16                     number of swaps performed
//   err_len      out  1                      sticky image-length error
// ----------------------------------------------------------------------------
module spike_time_encoder
   import spike_time_encoder_pkg::*;
#(
   parameter int NUM_SPIKES    = DEF_NUM_SPIKES,
   parameter int PIXEL_W       = DEF_PIXEL_W,
   parameter int TIME_W        = DEF_TIME_W,
   parameter int TVAL_W        = DEF_TVAL_W,
   parameter int TRAIN_PERIOD  = DEF_TRAIN_PERIOD,
   parameter int TEST_PERIOD   = DEF_TEST_PERIOD,
   parameter int MIN_INTENSITY = DEF_MIN_INTENSITY
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                training,
   input  logic [TVAL_W-1:0]                   time_val,
   input  logic                                pix_valid,
   output logic                                pix_ready,
   input  logic [PIXEL_W-1:0]                  pix_data,
   input  logic                                pix_last,
   output logic [NUM_SPIKES-1:0][TIME_W-1:0]   spike_times,
   output logic                                frame_valid,
   output logic [15:0]                         frame_cnt,
   output logic                                err_len
);

   localparam int IDX_W = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SPIKES - 1);
   localparam logic [TVAL_W-1:0] TRAIN_END = TVAL_W'(TRAIN_PERIOD - 1);
   localparam logic [TVAL_W-1:0] TEST_END  = TVAL_W'(TEST_PERIOD - 1);
   // Same all-ones code as the package NO_SPIKE, sized to this TIME_W.
   localparam logic [TIME_W-1:0] NO_SPIKE_CODE = '1;

   enc_state_t                        state;
   enc_state_t                        state_nxt;
   logic [IDX_W-1:0]                  idx;
   logic                              discard;
   logic [NUM_SPIKES-1:0][TIME_W-1:0] shadow;
   logic [TIME_W-1:0]                 pix_time;
   logic                              accept;
   logic                              period_end;
   logic                              swap;
   logic                              img_done;

   spike_time_encode #(
      .PIXEL_W       (PIXEL_W),
      .TIME_W        (TIME_W),
      .MIN_INTENSITY (MIN_INTENSITY)
   ) u_encode (
      .pix        (pix_data),
      .spike_time (pix_time)
   );

   assign pix_ready  = (state == FILL);
   assign accept     = pix_valid & pix_ready;
   // training is sampled every cycle, so a mid-period change applies at the
   // next period end that matches the new length.
   assign period_end = (time_val == (training ? TRAIN_END : TEST_END));
   assign swap       = period_end & (state == FULL);
   // Pixels tagged as the tail of an over-long image never complete a frame.
   assign img_done   = accept & ~discard & (pix_last | (idx == LAST_IDX));

`ifdef ENCODER_BLANK_ON_UNDERRUN_EN
   logic underrun;
   assign underrun = period_end & (state == FILL);
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: next-state gets a default before the case so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (img_done) state_nxt = FULL;
         FULL:    if (swap)     state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // NOTE: the shadow buffer is a small flop array and is reset on purpose:
   // entries never written by a short image must already read NO_SPIKE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= '0;
         discard     <= 1'b0;
         shadow      <= {NUM_SPIKES{NO_SPIKE_CODE}};
         spike_times <= {NUM_SPIKES{NO_SPIKE_CODE}};
         frame_valid <= 1'b0;
         frame_cnt   <= '0;
         err_len     <= 1'b0;
      end else begin
         if (swap) begin
            spike_times <= shadow;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
            idx         <= '0;
            shadow      <= {NUM_SPIKES{NO_SPIKE_CODE}};
         end
`ifdef ENCODER_BLANK_ON_UNDERRUN_EN
         else if (underrun) begin
            spike_times <= {NUM_SPIKES{NO_SPIKE_CODE}};
            frame_valid <= 1'b0;
         end
`endif

         // A swap only happens in FULL, where pix_ready is low, so the
         // shadow writes below never collide with the swap above.
         if (accept) begin
            if (discard) begin
               if (pix_last) discard <= 1'b0;
            end else begin
               shadow[idx] <= pix_time;
               if (pix_last) begin
                  if (idx != LAST_IDX) begin
                     err_len <= 1'b1;
                     for (int i = 0; i < NUM_SPIKES; i++) begin
                        if (i > int'(idx)) shadow[i] <= NO_SPIKE_CODE;
                     end
                  end
               end else if (idx == LAST_IDX) begin
                  // Frame is full but the image goes on: swallow the rest.
                  err_len <= 1'b1;
                  discard <= 1'b1;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spike_time_encoder.sv
// ----------------------------------------------------------------------------
// tb_spike_time_encoder
//   Directed testbench for spike_time_encoder. time_val is generated by a
//   free-running counter that wraps at the period chosen by training.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge. Define ENCODER_BLANK_ON_UNDERRUN_EN to match a blanking build.
// ----------------------------------------------------------------------------
module tb_spike_time_encoder;

   localparam int N = 16;
   typedef logic [N-1:0][3:0] st_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        training;
   logic [4:0]  time_val = '0;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pix_data;
   logic        pix_last;
   st_t         spike_times;
   logic        frame_valid;
   logic [15:0] frame_cnt;
   logic        err_len;

   int checks   = 0;
   int errors   = 0;
   int stalls   = 0;   // pixels that never saw pix_ready within budget
   st_t all_f   = '1;

   spike_time_encoder dut (
      .clk         (clk),
      .rst         (rst),
      .training    (training),
      .time_val    (time_val),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_data    (pix_data),
      .pix_last    (pix_last),
      .spike_times (spike_times),
      .frame_valid (frame_valid),
      .frame_cnt   (frame_cnt),
      .err_len     (err_len)
   );

   always #5 clk = ~clk;

   // Global period counter; moves shortly after the edge so the DUT sees a
   // stable value at every rising edge.
   always @(posedge clk) begin
      #2;
      if (time_val >= (training ? 5'd23 : 5'd7)) time_val = 5'd0;
      else                                       time_val = time_val + 5'd1;
   end

   task automatic send_pixel(input logic [7:0] d, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = last;
      while (!pix_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!pix_ready) stalls++;
      @(posedge clk);
   endtask

   task automatic end_burst;
      @(negedge clk);
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic wait_swap(input logic [15:0] cnt_before, output bit timed_out);
      int n;
      n = 0;
      while (frame_cnt === cnt_before && n < 100) begin
         @(negedge clk);
         n++;
      end
      timed_out = (frame_cnt === cnt_before);
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      training  = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      pix_last  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (spike_times !== all_f) begin errors++; $display("FAIL reset_spike_times: got %h want %h", spike_times, all_f); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
      checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len: got %b want 0", err_len); end
   endtask

   task automatic test_encode;
      logic [7:0] px [N];
      st_t e;
      bit  to;
      for (int i = 0; i < N; i++) px[i] = 8'd0;
      px[0] = 8'd255; px[1] = 8'd200; px[2] = 8'd128;
      px[3] = 8'd32;  px[4] = 8'd31;  px[5] = 8'd0;
      e = '1;
      e[0] = 4'h0; e[1] = 4'h1; e[2] = 4'h3; e[3] = 4'h6;
      for (int i = 0; i < N; i++) send_pixel(px[i], (i == N - 1));
      end_burst;
      checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL encode_ready_low: got %b want 0", pix_ready); end
      wait_swap(16'd0, to);
      checks++; if (to) begin errors++; $display("FAIL encode_swap_timeout: frame_cnt %0d want 1", frame_cnt); end
      checks++; if (time_val !== 5'd0) begin errors++; $display("FAIL encode_swap_time: time_val %0d want 0", time_val); end
      checks++; if (spike_times !== e) begin errors++; $display("FAIL encode_spike_times: got %h want %h", spike_times, e); end
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL encode_frame_valid: got %b want 1", frame_valid); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL encode_frame_cnt: got %0d want 1", frame_cnt); end
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL encode_err_len: got %b want 0", err_len); end
      checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL encode_ready_high: got %b want 1", pix_ready); end
      checks++; if (stalls !== 0) begin errors++; $display("FAIL encode_stalls: got %0d want 0", stalls); end
   endtask

   task automatic test_short;
      st_t e;
      bit  to;
      e = '1;
      e[0] = 4'h0; e[1] = 4'h0; e[2] = 4'h0;
      send_pixel(8'd255, 1'b0);
      send_pixel(8'd255, 1'b0);
      send_pixel(8'd255, 1'b1);
      end_burst;
      checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL short_ready_low: got %b want 0", pix_ready); end
      wait_swap(16'd1, to);
      checks++; if (to) begin errors++; $display("FAIL short_swap_timeout: frame_cnt %0d want 2", frame_cnt); end
      checks++; if (time_val !== 5'd0) begin errors++; $display("FAIL short_swap_time: time_val %0d want 0", time_val); end
      checks++; if (spike_times !== e) begin errors++; $display("FAIL short_spike_times: got %h want %h", spike_times, e); end
      checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL short_frame_cnt: got %0d want 2", frame_cnt); end
      checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL short_err_len: got %b want 1", err_len); end
   endtask

   task automatic test_long;
      logic [7:0] px [N + 2];
      st_t e;
      st_t e3;
      bit  to;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      px[0] = 8'd255; px[1] = 8'd224; px[2] = 8'd192; px[3] = 8'd160;
      px[4] = 8'd128; px[5] = 8'd96;  px[6] = 8'd64;  px[7] = 8'd32;
      for (int i = 8; i < N; i++) px[i] = 8'd255;
      px[N] = 8'd32; px[N + 1] = 8'd32;
      e = '0;
      e[2] = 4'h1; e[3] = 4'h2; e[4] = 4'h3; e[5] = 4'h4; e[6] = 4'h5; e[7] = 4'h6;
      for (int i = 0; i < N + 2; i++) send_pixel(px[i], (i == N + 1));
      end_burst;
      checks++; if (stalls !== 0) begin errors++; $display("FAIL long_stalls: got %0d want 0", stalls); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL long_frame_cnt: got %0d want 1", frame_cnt); end
      checks++; if (spike_times !== e) begin errors++; $display("FAIL long_spike_times: got %h want %h", spike_times, e); end
      checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL long_err_len: got %b want 1", err_len); end
      checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL long_ready_after_tail: got %b want 1", pix_ready); end
      // Next image must land at index 0 with nothing left over from the tail.
      for (int i = 0; i < N; i++) e3[i] = 4'h3;
      for (int i = 0; i < N; i++) send_pixel(8'd128, (i == N - 1));
      end_burst;
      wait_swap(16'd1, to);
      checks++; if (to) begin errors++; $display("FAIL long_next_timeout: frame_cnt %0d want 2", frame_cnt); end
      checks++; if (spike_times !== e3) begin errors++; $display("FAIL long_next_spike_times: got %h want %h", spike_times, e3); end
      checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL long_next_frame_cnt: got %0d want 2", frame_cnt); end
   endtask

   task automatic test_underrun;
      st_t e;
      int  n;
`ifdef ENCODER_BLANK_ON_UNDERRUN_EN
      e = '1;
`else
      for (int i = 0; i < N; i++) e[i] = 4'h3;
`endif
      @(negedge clk);
      training = 1'b1;
      n = 0;
      while (time_val !== 5'd23 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++; if (time_val !== 5'd23) begin errors++; $display("FAIL underrun_reach_23: time_val %0d want 23", time_val); end
      @(negedge clk);
      checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL underrun_frame_cnt: got %0d want 2", frame_cnt); end
      checks++; if (spike_times !== e) begin errors++; $display("FAIL underrun_spike_times: got %h want %h", spike_times, e); end
`ifdef ENCODER_BLANK_ON_UNDERRUN_EN
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL underrun_frame_valid: got %b want 0", frame_valid); end
`else
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL underrun_frame_valid: got %b want 1", frame_valid); end
`endif
      checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL underrun_ready: got %b want 1", pix_ready); end
   endtask

   task automatic test_training_swap;
      st_t e;
      bit  to;
      e = '1;
      e[0] = 4'h3; e[1] = 4'h5; e[2] = 4'h6;
      send_pixel(8'd128, 1'b0);
      send_pixel(8'd64,  1'b0);
      send_pixel(8'd32,  1'b1);
      end_burst;
      wait_swap(16'd2, to);
      checks++; if (to) begin errors++; $display("FAIL train_swap_timeout: frame_cnt %0d want 3", frame_cnt); end
      checks++; if (time_val !== 5'd0) begin errors++; $display("FAIL train_swap_time: time_val %0d want 0", time_val); end
      checks++; if (spike_times !== e) begin errors++; $display("FAIL train_spike_times: got %h want %h", spike_times, e); end
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL train_frame_valid: got %b want 1", frame_valid); end
      checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL train_frame_cnt: got %0d want 3", frame_cnt); end
   endtask

   task automatic test_reset_midfill;
      st_t e;
      bit  to;
      logic [3:0] tv [N];
      tv = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3,
             4'h4, 4'h4, 4'h5, 4'h5, 4'h6, 4'h6, 4'hF, 4'hF};
      for (int i = 0; i < N; i++) e[i] = tv[i];
      @(negedge clk);
      training = 1'b0;
      for (int i = 0; i < 5; i++) send_pixel(8'd255, 1'b0);
      @(negedge clk);
      pix_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (spike_times !== all_f) begin errors++; $display("FAIL midrst_spike_times: got %h want %h", spike_times, all_f); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL midrst_frame_valid: got %b want 0", frame_valid); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_frame_cnt: got %0d want 0", frame_cnt); end
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL midrst_err_len: got %b want 0", err_len); end
      checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL midrst_pix_ready: got %b want 1", pix_ready); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N; i++) send_pixel(8'(255 - 16 * i), (i == N - 1));
      end_burst;
      wait_swap(16'd0, to);
      checks++; if (to) begin errors++; $display("FAIL midrst_swap_timeout: frame_cnt %0d want 1", frame_cnt); end
      checks++; if (time_val !== 5'd0) begin errors++; $display("FAIL midrst_swap_time: time_val %0d want 0", time_val); end
      checks++; if (spike_times !== e) begin errors++; $display("FAIL midrst_spike_times_new: got %h want %h", spike_times, e); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL midrst_frame_cnt_new: got %0d want 1", frame_cnt); end
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL midrst_frame_valid_new: got %b want 1", frame_valid); end
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL midrst_err_len_new: got %b want 0", err_len); end
      checks++; if (stalls !== 0) begin errors++; $display("FAIL final_stalls: got %0d want 0", stalls); end
   endtask

   initial begin
      test_reset;
      test_encode;
      test_short;
      test_long;
      test_underrun;
      test_training_swap;
      test_reset_midfill;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
